// File: rtl/key_debounce.sv
// key_debounce: four independent push-button debouncers with press/release
// pulses, auto-repeat while held, and a priority-encoded code of the most
// recently accepted press. Raw keys are active-low and asynchronous to clk.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_repeat,
  output logic [1:0] key_code,
  output logic       key_valid
);

  // Counter only ever needs to reach (largest interval - 1).
  localparam int MAX_AB  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] press_next;
  logic [3:0] release_next;
  logic [3:0] repeat_next;
  logic [3:0] level_next;
  logic [1:0] code_next;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic [CNT_W-1:0] cnt_inc;
      // Set once the first (HOLD) repeat has fired; later repeats use REPEAT.
      logic             repeating_reg;
      logic             repeating_next;
      logic             key_low;
      logic             pulse_press;
      logic             pulse_release;
      logic             pulse_repeat;

      assign key_low = ~sync2_reg[gi];
      assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

      // Per-key state, counter and repeat-phase register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          repeating_reg <= 1'b0;
        end else begin
          state_reg     <= state_next;
          cnt_reg       <= cnt_next;
          repeating_reg <= repeating_next;
        end
      end

      // Next-state logic and event pulses for one key.
      always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        repeating_next = repeating_reg;
        pulse_press    = 1'b0;
        pulse_release  = 1'b0;
        pulse_repeat   = 1'b0;
        case (state_reg)
          IDLE: begin
            if (key_low) begin
              state_next = PRESS_WAIT;
              cnt_next   = '0;
            end
          end
          PRESS_WAIT: begin
            if (!key_low) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == DEB_LAST) begin
              state_next     = PRESSED;
              cnt_next       = '0;
              repeating_next = 1'b0;
              pulse_press    = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          PRESSED: begin
            if (!key_low) begin
              state_next = RELEASE_WAIT;
              cnt_next   = '0;
            end else if (!repeating_reg && cnt_reg == HOLD_LAST) begin
              pulse_repeat   = 1'b1;
              repeating_next = 1'b1;
              cnt_next       = '0;
            end else if (repeating_reg && cnt_reg == REPEAT_LAST) begin
              pulse_repeat = 1'b1;
              cnt_next     = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          RELEASE_WAIT: begin
            if (key_low) begin
              // Bounce during release: still held, repeat timing restarts.
              state_next     = PRESSED;
              cnt_next       = '0;
              repeating_next = 1'b0;
            end else if (cnt_reg == DEB_LAST) begin
              state_next    = IDLE;
              cnt_next      = '0;
              pulse_release = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      assign press_next[gi]   = pulse_press;
      assign release_next[gi] = pulse_release;
      assign repeat_next[gi]  = pulse_repeat;
      assign level_next[gi]   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end
  endgenerate

  // Lowest-index key wins when several presses are accepted together.
  always_comb begin
    code_next = 2'd0;
    if (press_next[0])      code_next = 2'd0;
    else if (press_next[1]) code_next = 2'd1;
    else if (press_next[2]) code_next = 2'd2;
    else if (press_next[3]) code_next = 2'd3;
  end

  // Registered outputs; key_code holds between accepted presses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_level   <= 4'h0;
      key_press   <= 4'h0;
      key_release <= 4'h0;
      key_repeat  <= 4'h0;
      key_valid   <= 1'b0;
      key_code    <= 2'd0;
    end else begin
      key_level   <= level_next;
      key_press   <= press_next;
      key_release <= release_next;
      key_repeat  <= repeat_next;
      key_valid   <= |press_next;
      if (|press_next) key_code <= code_next;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model pushes
// expected pulse events; a monitor pops and compares them each cycle.
module tb_key_debounce;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;
  logic [1:0] key_code;
  logic       key_valid;

  always #10 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYC(DEB),
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .key_code   (key_code),
    .key_valid  (key_valid)
  );

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
    logic       valid;
    logic [1:0] code;
  } ev_t;

  ev_t        evq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] exp_level;
  logic [1:0] exp_code;

  int         press_cnt[4];
  int         release_cnt[4];
  int         rep_cnt[4];
  int         last_press_cyc[4];
  int         last_release_cyc[4];
  logic [3:0] last_press_vec;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Reference model: a key is accepted after DEB+1 consecutive synchronized
  // samples at the new level; repeats fire on the HOLD-th held sample and
  // every REP samples after that.
  initial begin : model
    logic [3:0] m_s1, m_s2, v, pr, rl, rp;
    int         low_run[4], high_run[4], hold_n[4];
    bit         pressed[4];
    ev_t        e;
    m_s1 = 4'hF; m_s2 = 4'hF;
    exp_level = 4'h0; exp_code = 2'd0;
    for (int i = 0; i < 4; i++) begin
      low_run[i] = 0; high_run[i] = 0; hold_n[i] = 0; pressed[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_s1 = 4'hF; m_s2 = 4'hF;
        for (int i = 0; i < 4; i++) begin
          low_run[i] = 0; high_run[i] = 0; hold_n[i] = 0; pressed[i] = 0;
        end
        exp_level = 4'h0; exp_code = 2'd0;
      end else begin
        v = m_s2; m_s2 = m_s1; m_s1 = key_in;
        pr = 4'h0; rl = 4'h0; rp = 4'h0;
        for (int i = 0; i < 4; i++) begin
          if (!pressed[i]) begin
            if (!v[i]) begin
              low_run[i]++;
              if (low_run[i] == DEB + 1) begin
                pressed[i] = 1; pr[i] = 1'b1;
                hold_n[i] = 0; high_run[i] = 0; low_run[i] = 0;
              end
            end else begin
              low_run[i] = 0;
            end
          end else begin
            if (!v[i]) begin
              if (high_run[i] > 0) begin
                high_run[i] = 0; hold_n[i] = 0;
              end else begin
                hold_n[i]++;
                if (hold_n[i] == HOLD || (hold_n[i] > HOLD && (hold_n[i] - HOLD) % REP == 0))
                  rp[i] = 1'b1;
              end
            end else begin
              high_run[i]++;
              if (high_run[i] == DEB + 1) begin
                pressed[i] = 0; rl[i] = 1'b1; low_run[i] = 0;
              end
            end
          end
          exp_level[i] = pressed[i];
        end
        if (pr != 4'h0) begin
          if (pr[0])      exp_code = 2'd0;
          else if (pr[1]) exp_code = 2'd1;
          else if (pr[2]) exp_code = 2'd2;
          else            exp_code = 2'd3;
        end
        if ((pr | rl | rp) != 4'h0) begin
          e.cyc = cyc; e.press = pr; e.rel = rl; e.rep = rp;
          e.valid = (pr != 4'h0); e.code = exp_code;
          evq.push_back(e);
        end
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge against the scoreboard.
  initial begin : monitor
    ev_t e;
    for (int i = 0; i < 4; i++) begin
      last_press_cyc[i] = -1; last_release_cyc[i] = -1;
    end
    last_press_vec = 4'h0;
    forever begin
      @(negedge clk);
      chk("level", int'(key_level), int'(exp_level));
      chk("code", int'(key_code), int'(exp_code));
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        chk("missed_event", 0, e.cyc);
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        chk("event", int'({key_press, key_release, key_repeat, key_valid, key_code}),
            int'({e.press, e.rel, e.rep, e.valid, e.code}));
      end else begin
        chk("no_pulse", int'({key_press, key_release, key_repeat, key_valid}), 0);
      end
      for (int i = 0; i < 4; i++) begin
        if (key_press[i])   begin press_cnt[i]++; last_press_cyc[i] = cyc; end
        if (key_release[i]) begin release_cnt[i]++; last_release_cyc[i] = cyc; end
        if (key_repeat[i])  rep_cnt[i]++;
      end
      if (key_valid) last_press_vec = key_press;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed scenarios, then randomized bouncing and resets.
  initial begin : stim
    int         c, r0, p0, q0;
    int         r, hold;
    logic [3:0] k;
    rst_n  = 1'b0;
    key_in = 4'hF;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);

    // Single press on key 0: accepted DEB+3 edges later, then released.
    c = cyc; key_in = 4'b1110; wait_cyc(10);
    chk("press_latency_k0", last_press_cyc[0], c + 7);
    c = cyc; key_in = 4'hF; wait_cyc(10);
    chk("release_latency_k0", last_release_cyc[0], c + 7);

    // Short glitch on key 1 is rejected.
    key_in = 4'b1101; wait_cyc(3); key_in = 4'hF; wait_cyc(10);
    chk("glitch_k1_press", press_cnt[1], 0);

    // Long hold on key 2: five repeats, release seven edges after key up.
    r0 = rep_cnt[2];
    key_in = 4'b1011; wait_cyc(60);
    c = cyc; key_in = 4'hF; wait_cyc(10);
    chk("repeat_count_k2", rep_cnt[2] - r0, 5);
    chk("release_latency_k2", last_release_cyc[2], c + 7);

    // Simultaneous presses on keys 1 and 3.
    key_in = 4'b0101; wait_cyc(10);
    chk("simul_press_vec", int'(last_press_vec), 4'b1010);
    chk("simul_code", int'(key_code), 1);
    key_in = 4'hF; wait_cyc(10);

    // Key 3 with a bounce inside the release window.
    p0 = press_cnt[3]; q0 = release_cnt[3];
    key_in = 4'b0111; wait_cyc(10);
    key_in = 4'hF; wait_cyc(2);
    key_in = 4'b0111; wait_cyc(2);
    key_in = 4'hF; wait_cyc(12);
    chk("bounce_k3_press", press_cnt[3] - p0, 1);
    chk("bounce_k3_release", release_cnt[3] - q0, 1);

    // Reset while key 0 is held: fresh debounce afterwards.
    key_in = 4'b1110; wait_cyc(10);
    rst_n = 1'b0; wait_cyc(1);
    c = cyc; rst_n = 1'b1; wait_cyc(10);
    chk("press_after_reset_k0", last_press_cyc[0], c + 7);
    key_in = 4'hF; wait_cyc(10);

    // Randomized bouncing, holds and occasional resets.
    for (int it = 0; it < 160; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      k = key_in ^ (4'b0001 << $urandom_range(0, 3));
      else if (r < 9) k = 4'($urandom);
      else            k = key_in;
      key_in = k;
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        wait_cyc($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      hold = $urandom_range(1, 30);
      wait_cyc(hold);
    end

    key_in = 4'hF; wait_cyc(20);
    chk("queue_empty", evq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 1000000, stable-level cycles required to accept a press or release (20 ms at 50 MHz).
REQ-002 SHALL have parameter HOLD_CYC, default 50000000, cycles a key stays pressed before the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_CYC, default 10000000, cycles between later auto-repeat pulses.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port key_in  input  4  raw push-button levels, active-low (0 = pressed), asynchronous to clk.
REQ-007 SHALL have port key_level  output  4  debounced state per key, active-high (1 = pressed).
REQ-008 SHALL have port key_press  output  4  one-cycle pulse per key on accepted press.
REQ-009 SHALL have port key_release  output  4  one-cycle pulse per key on accepted release.
REQ-010 SHALL have port key_repeat  output  4  one-cycle pulse per key for each auto-repeat event while held.
REQ-011 SHALL have port key_code  output  2  index of the most recently accepted press.
REQ-012 SHALL have port key_valid  output  1  one-cycle pulse qualifying key_code.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchronizer (reset value 1) before use.
REQ-014 Each key SHALL have an independent FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a counter sized for max(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC).
REQ-015 IDLE: synchronized key low -> PRESS_WAIT, counter=0; else stay.
REQ-016 PRESS_WAIT: key high -> IDLE (glitch rejected, no outputs); key low with counter==DEBOUNCE_CYC-1 -> PRESSED, key_press pulse, counter=0; else counter+1.
REQ-017 PRESSED: key_level=1; key high -> RELEASE_WAIT, counter=0; else counter+1, with key_repeat pulse when counter reaches HOLD_CYC-1 (first) and every REPEAT_CYC cycles thereafter.
REQ-018 RELEASE_WAIT: key_level stays 1; key low -> PRESSED, no new key_press, repeat timing restarts from 0; key high with counter==DEBOUNCE_CYC-1 -> IDLE, key_release pulse, key_level=0; else counter+1.
REQ-019 All outputs SHALL be registered; with key_in held low from rising edge N, key_press SHALL be high during the cycle after edge N+DEBOUNCE_CYC+2 (latency DEBOUNCE_CYC+3 edges); release latency identical.
REQ-020 key_press/key_release/key_repeat SHALL each be high for exactly one cycle per event.
REQ-021 key_valid SHALL pulse in the same cycle as any key_press bit; key_code SHALL equal the lowest index among simultaneous key_press bits and hold its value until the next key_valid.
REQ-022 Simultaneous presses on several keys SHALL assert all corresponding key_press bits in the same cycle.
REQ-023 key_repeat SHALL NOT update key_code or key_valid.
REQ-024 Counters SHALL saturate, never wrap, in any state.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force all FSMs to IDLE, counters to 0, synchronizers to 1, key_level=0, key_press=0, key_release=0, key_repeat=0, key_valid=0, key_code=0.
REQ-026 Reset asserted mid-press SHALL discard the press; after release of reset a still-held key SHALL need a full debounce interval and SHALL produce a fresh key_press.
REQ-027 No pulse output SHALL assert in the first cycle after reset deasserts.

Verification (DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8, 20 ns clock)
REQ-028 key_in=4'b1110 held from edge N -> key_press=4'b0001 and key_valid=1 one cycle after edge N+6, key_code=0, key_level[0]=1.
REQ-029 key_in[1] low for 3 cycles then high -> no key_press, key_level stays 0.
REQ-030 key_in[2] held low 60 cycles -> one key_press, key_repeat[2] at counter 19, 27, 35, 43, 51 (5 pulses), then key_release 7 edges after key_in returns high.
REQ-031 key_in=4'b0101 in the same cycle -> key_press=4'b1010 in one cycle, key_code=1.
REQ-032 Press key 3, release, bounce low for 2 cycles inside RELEASE_WAIT -> key_level[3] stays 1, no second key_press, single key_release after stable high.
REQ-033 rst_n=0 while key 0 in PRESSED, key held low -> all outputs 0 next cycle; after rst_n=1 key_press[0] again after 7 edges.
